// File: rtl/dm_rmw_responder.sv
// Data-memory responder for the MEM stage: word reads and 1-4 byte writes against a
// single-port word-wide SRAM without byte enables, using read-modify-write for partial writes.
module dm_rmw_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  Req_IN,
    input  logic                  Write_IN,
    input  logic [31:0]           Address_IN,
    input  logic [1:0]            DataSize_IN,
    input  logic [31:0]           Data_IN,
    output logic [31:0]           Data_OUT,
    output logic                  Ready_OUT,
    output logic                  Done_OUT,
    output logic                  Error_OUT,
    output logic                  SramEN_OUT,
    output logic                  SramWE_OUT,
    output logic [ADDR_WIDTH-1:0] SramAddr_OUT,
    output logic [31:0]           SramWData_OUT,
    input  logic [31:0]           SramRData_IN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RCAP,
        S_MRD,
        S_MCAP,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [1:0]  offset_q;
    logic [2:0]  count_q;
    logic [31:0] data_q;

    logic [2:0]  req_count;
    logic        req_cross;
    logic        req_full;
    logic        unused_addr;

    // Size code 0 encodes a four-byte run; the run crosses the word if offset + count > 4.
    assign req_count   = (DataSize_IN == 2'd0) ? 3'd4 : {1'b0, DataSize_IN};
    assign req_cross   = ({1'b0, Address_IN[1:0]} + req_count) > 3'd4;
    assign req_full    = (DataSize_IN == 2'd0) && (Address_IN[1:0] == 2'd0);
    assign unused_addr = ^{Address_IN[31:ADDR_WIDTH+2]};

    // Byte lane (offset + i) takes the i-th byte of the right-justified run, most significant first.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] run_data,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  count);
        logic [31:0] result;
        int          idx;
        result = old_word;
        for (int lane = 0; lane < 4; lane++) begin
            idx = lane - int'(offset);
            if (idx >= 0 && idx < int'(count))
                result[31-8*lane -: 8] = run_data[8*(int'(count)-1-idx) +: 8];
        end
        return result;
    endfunction

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= S_IDLE;
            Data_OUT      <= '0;
            Ready_OUT     <= 1'b1;
            Done_OUT      <= 1'b0;
            Error_OUT     <= 1'b0;
            SramEN_OUT    <= 1'b0;
            SramWE_OUT    <= 1'b0;
            SramAddr_OUT  <= '0;
            SramWData_OUT <= '0;
            offset_q      <= '0;
            count_q       <= '0;
            data_q        <= '0;
        end else begin
            // NOTE: pulse outputs default low here with non-blocking assignments; a state that
            // needs them high overrides below, so each pulse lasts exactly one cycle.
            Done_OUT   <= 1'b0;
            Error_OUT  <= 1'b0;
            SramEN_OUT <= 1'b0;
            SramWE_OUT <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Req_IN) begin
                        Ready_OUT    <= 1'b0;
                        SramAddr_OUT <= Address_IN[ADDR_WIDTH+1:2];
                        offset_q     <= Address_IN[1:0];
                        count_q      <= req_count;
                        data_q       <= Data_IN;
                        if (!Write_IN) begin
                            state      <= S_READ;
                            SramEN_OUT <= 1'b1;
                        end else if (req_cross) begin
                            state     <= S_ERR;
                            Done_OUT  <= 1'b1;
                            Error_OUT <= 1'b1;
                        end else if (req_full) begin
                            state         <= S_WRITE;
                            SramEN_OUT    <= 1'b1;
                            SramWE_OUT    <= 1'b1;
                            SramWData_OUT <= Data_IN;
                        end else begin
                            state      <= S_MRD;
                            SramEN_OUT <= 1'b1;
                        end
                    end
                end
                S_READ: state <= S_RCAP;
                S_RCAP: begin
                    Data_OUT <= SramRData_IN;
                    Done_OUT <= 1'b1;
                    state    <= S_DONE;
                end
                S_MRD: state <= S_MCAP;
                S_MCAP: begin
                    SramWData_OUT <= merge_word(SramRData_IN, data_q, offset_q, count_q);
                    SramEN_OUT    <= 1'b1;
                    SramWE_OUT    <= 1'b1;
                    state         <= S_WRITE;
                end
                S_WRITE: begin
                    Done_OUT <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    Ready_OUT <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_rmw_responder.sv
// Self-checking bench for dm_rmw_responder: behavioural SRAM, expectation queue per request,
// and scenario tasks covering reads, full/partial writes, errors, reset abort and back-to-back.
module tb_dm_rmw_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic        write;
    logic [31:0] address;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] data_out;
    logic        ready;
    logic        done;
    logic        error;
    logic        sram_en;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_cnt    = 0;
    int rd_cnt    = 0;
    logic [31:0] last_rd = 32'h0;

    logic [31:0] mem [0:1023];

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] data;
        int          wr;
        int          rd;
        logic [9:0]  waddr;
    } exp_t;

    exp_t exp_q [$];

    dm_rmw_responder #(.ADDR_WIDTH(10)) dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .Req_IN       (req),
        .Write_IN     (write),
        .Address_IN   (address),
        .DataSize_IN  (size),
        .Data_IN      (wdata),
        .Data_OUT     (data_out),
        .Ready_OUT    (ready),
        .Done_OUT     (done),
        .Error_OUT    (error),
        .SramEN_OUT   (sram_en),
        .SramWE_OUT   (sram_we),
        .SramAddr_OUT (sram_addr),
        .SramWData_OUT(sram_wdata),
        .SramRData_IN (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: read data appears the cycle after the enable cycle.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                mem[sram_addr] <= sram_wdata;
                wr_cnt         <= wr_cnt + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
                rd_cnt     <= rd_cnt + 1;
            end
        end
    end

    // Wait (bounded) for Done at negedges; lat counts cycles after the accept cycle.
    task automatic wait_done(output int lat, output logic seen);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 12) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic compare_done(input string name, input exp_t e, input int lat, input logic seen,
                                input int wr0, input int rd0);
        total_cnt++;
        if (!seen) $display("FAIL %s done: no Done within 12 cycles, required at cycle %0d", name, e.lat);
        else pass_cnt++;
        if (seen) begin
            total_cnt++;
            if (lat !== e.lat) $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
            else pass_cnt++;
            total_cnt++;
            if (error !== e.err) $display("FAIL %s error: got %b required %b", name, error, e.err);
            else pass_cnt++;
            total_cnt++;
            if (data_out !== e.data) $display("FAIL %s data_out: got %h required %h", name, data_out, e.data);
            else pass_cnt++;
            total_cnt++;
            if (ready !== 1'b0) $display("FAIL %s ready_at_done: got %b required 0", name, ready);
            else pass_cnt++;
            total_cnt++;
            if (e.err === 1'b0 && sram_addr !== e.waddr)
                $display("FAIL %s sram_addr: got %h required %h", name, sram_addr, e.waddr);
            else pass_cnt++;
        end
        total_cnt++;
        if (wr_cnt - wr0 !== e.wr) $display("FAIL %s sram_writes: got %0d required %0d", name, wr_cnt - wr0, e.wr);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt - rd0 !== e.rd) $display("FAIL %s sram_reads: got %0d required %0d", name, rd_cnt - rd0, e.rd);
        else pass_cnt++;
    endtask

    task automatic transact(input string name, input logic w, input logic [31:0] addr,
                            input logic [1:0] sz, input logic [31:0] data, input logic [31:0] exp_data,
                            input logic exp_err, input int exp_lat, input int exp_wr, input int exp_rd);
        exp_t e;
        int   wr0, rd0, lat, k;
        logic seen;
        e.lat = exp_lat; e.err = exp_err; e.data = exp_data;
        e.wr = exp_wr; e.rd = exp_rd; e.waddr = addr[11:2];
        exp_q.push_back(e);
        @(negedge clk);
        req = 1'b1; write = w; address = addr; size = sz; wdata = data;
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        total_cnt++;
        if (!ready) $display("FAIL %s ready_before: got 0 required 1", name);
        else pass_cnt++;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(posedge clk);
        @(negedge clk);
        // Scramble everything after accept: the request must already be latched.
        req = 1'b0; write = ~w; address = $urandom; size = 2'($urandom); wdata = $urandom;
        wait_done(lat, seen);
        e = exp_q.pop_front();
        compare_done(name, e, lat, seen, wr0, rd0);
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || done !== 1'b0)
            $display("FAIL %s after_done: ready=%b done=%b required ready=1 done=0", name, ready, done);
        else pass_cnt++;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
        int   n, lat;
        logic err, full;
        n    = (sz == 2'd0) ? 4 : int'(sz);
        err  = (int'(addr[1:0]) + n) > 4;
        full = (n == 4) && (addr[1:0] == 2'd0);
        lat  = err ? 1 : (full ? 2 : 4);
        transact(name, 1'b1, addr, sz, data, last_rd, err, lat, err ? 0 : 1, (err || full) ? 0 : 1);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_word);
        transact(name, 1'b0, addr, 2'($urandom), $urandom, exp_word, 1'b0, 3, 0, 1);
        last_rd = exp_word;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; write = 1'b0; address = '0; size = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (data_out !== 32'h0 || ready !== 1'b1 || done !== 1'b0 || error !== 1'b0)
            $display("FAIL reset_status: data=%h ready=%b done=%b error=%b required 0/1/0/0",
                     data_out, ready, done, error);
        else pass_cnt++;
        total_cnt++;
        if (sram_en !== 1'b0 || sram_we !== 1'b0 || sram_addr !== 10'h0 || sram_wdata !== 32'h0)
            $display("FAIL reset_sram: en=%b we=%b addr=%h wdata=%h required all 0",
                     sram_en, sram_we, sram_addr, sram_wdata);
        else pass_cnt++;
    endtask

    task automatic test_full_write_read;
        wr("full_write_10", 32'h10, 2'd0, 32'hDEADBEEF);
        rd("read_10", 32'h10, 32'hDEADBEEF);
        rd("read_10_high_bits", 32'hFFFF_F010, 32'hDEADBEEF);
    endtask

    task automatic test_byte_write;
        wr("preload_20", 32'h20, 2'd0, 32'h11223344);
        wr("byte_write_22", 32'h22, 2'd1, 32'h000000AB);
        rd("readback_byte_22", 32'h20, 32'h1122AB44);
        wr("restore_20a", 32'h20, 2'd0, 32'h11223344);
        wr("byte_write_23", 32'h23, 2'd1, 32'hFFFFFF55);
        rd("readback_byte_23", 32'h20, 32'h11223355);
    endtask

    task automatic test_partial_writes;
        wr("restore_20b", 32'h20, 2'd0, 32'h11223344);
        wr("tri_write_21", 32'h21, 2'd3, 32'h00AABBCC);
        rd("readback_tri_21", 32'h20, 32'h11AABBCC);
        wr("restore_20c", 32'h20, 2'd0, 32'h11223344);
        wr("tri_write_20", 32'h20, 2'd3, 32'h00AABBCC);
        rd("readback_tri_20", 32'h20, 32'hAABBCC44);
        wr("restore_20d", 32'h20, 2'd0, 32'h11223344);
        wr("half_write_22", 32'h22, 2'd2, 32'h0000BEEF);
        rd("readback_half_22", 32'h20, 32'h1122BEEF);
    endtask

    task automatic test_errors;
        wr("restore_20e", 32'h20, 2'd0, 32'h11223344);
        rd("read_before_err", 32'h10, 32'hDEADBEEF);
        wr("err_half_23", 32'h23, 2'd2, 32'h0000CAFE);
        wr("err_word_21", 32'h21, 2'd0, 32'hCAFEF00D);
        wr("err_tri_22", 32'h22, 2'd3, 32'h00123456);
        rd("readback_after_err", 32'h20, 32'h11223344);
    endtask

    task automatic test_reset_abort;
        int   wr0, n_done;
        wr("restore_20f", 32'h20, 2'd0, 32'h11223344);
        @(negedge clk);
        req = 1'b1; write = 1'b1; address = 32'h22; size = 2'd1; wdata = 32'h000000AB;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || done !== 1'b0 || sram_en !== 1'b0 || sram_we !== 1'b0)
            $display("FAIL abort_state: ready=%b done=%b en=%b we=%b required 1/0/0/0",
                     ready, done, sram_en, sram_we);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== 32'h0) $display("FAIL abort_data_out: got %h required 0", data_out);
        else pass_cnt++;
        rst = 1'b0;
        last_rd = 32'h0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        total_cnt++;
        if (n_done !== 0) $display("FAIL abort_no_done: got %0d Done pulses required 0", n_done);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt - wr0 !== 0) $display("FAIL abort_no_write: got %0d writes required 0", wr_cnt - wr0);
        else pass_cnt++;
        rd("readback_after_abort", 32'h20, 32'h11223344);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   wr0, rd0, lat;
        logic seen;
        e.lat = 2; e.err = 1'b0; e.data = last_rd; e.wr = 1; e.rd = 0; e.waddr = 10'h00C;
        exp_q.push_back(e);
        e.waddr = 10'h00D; e.wr = 1;
        exp_q.push_back(e);
        @(negedge clk);
        req = 1'b1; write = 1'b1; address = 32'h30; size = 2'd0; wdata = 32'hA5A5_0001;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(posedge clk);
        @(negedge clk);
        address = 32'h34; wdata = 32'h5A5A_0002;
        wait_done(lat, seen);
        e = exp_q.pop_front();
        compare_done("b2b_first", e, lat, seen, wr0, rd0);
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || sram_en !== 1'b0)
            $display("FAIL b2b_gap: ready=%b en=%b required 1/0", ready, sram_en);
        else pass_cnt++;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; wdata = $urandom; address = $urandom;
        wait_done(lat, seen);
        e = exp_q.pop_front();
        compare_done("b2b_second", e, lat, seen, wr0, rd0);
        @(negedge clk);
        rd("readback_b2b_30", 32'h30, 32'hA5A5_0001);
        rd("readback_b2b_34", 32'h34, 32'h5A5A_0002);
    endtask

    initial begin
        test_reset;
        test_full_write_read;
        test_byte_write;
        test_partial_writes;
        test_errors;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
